// File: rtl/alfsr_seq.sv
// rtl/alfsr_seq.sv - ALFSR configuration loader, reset sequencer and random byte packer
//
// Purpose: on start, shifts cfg_word MSB-first into an external LFSR configurator
// (lfsr_clk_o/lfsr_dat_o), holds the ALFSR core in reset for SETTLE cycles, then
// samples the synchronised rng_in every SAMPLE_DIV cycles and packs 8 samples per byte.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, stop        run request (IDLE only) / return to IDLE (RUN only, level)
//   cfg_word           configuration word, captured on accepted start
//   lfsr_clk_o         serial clock to configurator (registered, glitch-free)
//   lfsr_dat_o         serial data to configurator, MSB first
//   alfsr_rst_n_o      active-low reset to ALFSR core, high only in RUN
//   rng_in             asynchronous ALFSR output
//   byte_o/byte_valid  packed byte and its valid flag
//   byte_ready         consumer ready
//   busy               high in any state other than IDLE
//   overrun            sticky dropped-byte flag, cleared on accepted start
module alfsr_seq #(
  parameter int CFG_BITS   = 16,
  parameter int CLK_DIV    = 4,
  parameter int SETTLE     = 8,
  parameter int SAMPLE_DIV = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [CFG_BITS-1:0] cfg_word,
  output logic                lfsr_clk_o,
  output logic                lfsr_dat_o,
  output logic                alfsr_rst_n_o,
  input  logic                rng_in,
  output logic [7:0]          byte_o,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                busy,
  output logic                overrun
);

  localparam int PW = $clog2(2*CLK_DIV + 1);
  localparam int BW = $clog2(CFG_BITS + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int DW = $clog2(SAMPLE_DIV + 1);

  localparam logic [PW-1:0] PH_LAST   = PW'(2*CLK_DIV - 1);
  localparam logic [PW-1:0] PH_RISE   = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CFG_BITS - 1);
  localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE - 1);
  localparam logic [DW-1:0] SMP_LAST  = DW'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ARST, RUN} state_t;

  state_t              state, state_nxt;
  logic [CFG_BITS-1:0] shreg;
  logic [PW-1:0]       ph_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [SW-1:0]       set_cnt;
  logic [DW-1:0]       smp_cnt;
  logic [2:0]          pack_cnt;
  logic [7:0]          packer;
  logic [1:0]          sync;

  logic ph_end, load_done, settle_done, sample_en, byte_done, handshake;
  logic [7:0] pack_nxt;

  assign ph_end      = (state == LOAD) && (ph_cnt == PH_LAST);
  assign load_done   = ph_end && (bit_cnt == BIT_LAST);
  assign settle_done = (state == ARST) && (set_cnt == SET_LAST);
  // stop wins over a coincident sample: the partial byte is discarded anyway
  assign sample_en   = (state == RUN) && !stop && (smp_cnt == SMP_LAST);
  assign byte_done   = sample_en && (pack_cnt == 3'd7);
  assign handshake   = byte_valid && byte_ready;
  assign pack_nxt    = {packer[6:0], sync[1]};

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start)       state_nxt = LOAD;
      LOAD:    if (load_done)   state_nxt = ARST;
      ARST:    if (settle_done) state_nxt = RUN;
      RUN:     if (stop)        state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      shreg         <= '0;
      ph_cnt        <= '0;
      bit_cnt       <= '0;
      set_cnt       <= '0;
      smp_cnt       <= '0;
      pack_cnt      <= '0;
      packer        <= '0;
      sync          <= '0;
      lfsr_clk_o    <= 1'b0;
      lfsr_dat_o    <= 1'b0;
      alfsr_rst_n_o <= 1'b0;
      byte_o        <= '0;
      byte_valid    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state <= state_nxt;
      sync  <= {sync[0], rng_in};

      case (state)
        IDLE: begin
          if (start) begin
            shreg      <= cfg_word;
            lfsr_dat_o <= cfg_word[CFG_BITS-1];
            ph_cnt     <= '0;
            bit_cnt    <= '0;
            overrun    <= 1'b0;
          end
        end
        LOAD: begin
          if (ph_end) begin
            // falling edge of lfsr_clk_o: advance to the next bit
            ph_cnt     <= '0;
            lfsr_clk_o <= 1'b0;
            shreg      <= shreg << 1;
            if (load_done) begin
              lfsr_dat_o <= 1'b0;
              set_cnt    <= '0;
            end else begin
              lfsr_dat_o <= shreg[CFG_BITS-2];
              bit_cnt    <= bit_cnt + 1'b1;
            end
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
            if (ph_cnt == PH_RISE) lfsr_clk_o <= 1'b1;
          end
        end
        ARST: begin
          if (settle_done) begin
            alfsr_rst_n_o <= 1'b1;
            smp_cnt       <= '0;
            pack_cnt      <= '0;
            packer        <= '0;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            alfsr_rst_n_o <= 1'b0;
            smp_cnt       <= '0;
            pack_cnt      <= '0;
            packer        <= '0;
          end else if (sample_en) begin
            smp_cnt  <= '0;
            packer   <= pack_nxt;
            pack_cnt <= pack_cnt + 3'd1;
          end else begin
            smp_cnt <= smp_cnt + 1'b1;
          end
        end
        default: ;
      endcase

      // output byte register: a handshake frees the slot in the same cycle
      if (byte_done) begin
        if (!byte_valid || handshake) begin
          byte_o     <= pack_nxt;
          byte_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (handshake) begin
        byte_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alfsr_seq.sv
// tb/tb_alfsr_seq.sv - scoreboard testbench for alfsr_seq
module tb_alfsr_seq;

  localparam int CFG_BITS   = 16;
  localparam int CLK_DIV    = 4;
  localparam int SETTLE     = 8;
  localparam int SAMPLE_DIV = 2;
  localparam int LOAD_CYC   = CFG_BITS * 2 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] cfg_word = '0;
  logic        rng_in = 1'b0;
  logic        byte_ready = 1'b0;
  logic        lfsr_clk_o, lfsr_dat_o, alfsr_rst_n_o, byte_valid, busy, overrun;
  logic [7:0]  byte_o;

  alfsr_seq #(
    .CFG_BITS(CFG_BITS), .CLK_DIV(CLK_DIV), .SETTLE(SETTLE), .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_word(cfg_word),
    .lfsr_clk_o(lfsr_clk_o), .lfsr_dat_o(lfsr_dat_o), .alfsr_rst_n_o(alfsr_rst_n_o),
    .rng_in(rng_in), .byte_o(byte_o), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         cyc = 0;
  int         m_r0 = 0;
  logic       m_idle = 1'b1, m_run = 1'b0, m_pend = 1'b0, m_ovr = 1'b0;
  int         nsamp = 0;
  logic [7:0] pack = '0;
  logic       hist [64];
  logic [7:0] exp_q [$];

  always @(posedge clk) begin : model
    logic hs, done;
    cyc++;
    hist[cyc & 63] = rng_in;
    done = 1'b0;
    if (rst) begin
      m_idle = 1'b1; m_run = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
      nsamp = 0; pack = '0;
      exp_q.delete();
    end else begin
      hs = m_pend && byte_ready;
      if (m_idle) begin
        if (start) begin
          m_idle = 1'b0;
          m_ovr  = 1'b0;
          m_r0   = cyc + LOAD_CYC + SETTLE;
        end
      end else if (!m_run) begin
        if (cyc == m_r0) m_run = 1'b1;
      end else if (stop) begin
        m_idle = 1'b1; m_run = 1'b0; nsamp = 0; pack = '0;
      end else if (((cyc - m_r0) % SAMPLE_DIV) == 0) begin
        // two synchroniser flops: the sample sees rng_in as it was two edges ago
        pack = {pack[6:0], hist[(cyc - 2) & 63]};
        nsamp++;
        if (nsamp == 8) begin
          nsamp = 0;
          done  = 1'b1;
        end
      end
      if (done) begin
        if (!m_pend || hs) begin
          exp_q.push_back(pack);
          m_pend = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (hs) begin
        m_pend = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, !m_idle);
      chk("alfsr_rst_n", alfsr_rst_n_o, m_run);
      chk("byte_valid", byte_valid, m_pend);
      chk("overrun", overrun, m_ovr);
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL byte_unexpected: got %0h expected none", byte_o);
        end else begin
          chk("byte_o", byte_o, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] cfg);
    cfg_word = cfg;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_rst_vals(input string tag);
    chk({tag, "_lfsr_clk"}, lfsr_clk_o, 0);
    chk({tag, "_lfsr_dat"}, lfsr_dat_o, 0);
    chk({tag, "_alfsr_rst_n"}, alfsr_rst_n_o, 0);
    chk({tag, "_byte_o"}, byte_o, 0);
    chk({tag, "_byte_valid"}, byte_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  // observes LOAD and ARST from the cycle after start until RUN is entered
  task automatic check_load(input logic [15:0] cfg);
    logic [15:0] cap = '0;
    logic prev = 1'b0, bitv = 1'b0;
    int nr = 0, first = -1, last = -1, gap_bad = 0, stab_bad = 0, nlow = 0;
    for (int i = 0; i < LOAD_CYC + SETTLE; i++) begin
      if (lfsr_clk_o && !prev) begin
        cap  = {cap[14:0], lfsr_dat_o};
        bitv = lfsr_dat_o;
        if (nr == 0) first = i;
        else if (i - last != 2 * CLK_DIV) gap_bad++;
        last = i;
        nr++;
      end else if (lfsr_clk_o && lfsr_dat_o !== bitv) begin
        stab_bad++;
      end
      if (alfsr_rst_n_o == 1'b0) nlow++;
      prev = lfsr_clk_o;
      step();
    end
    chk("load_rises", nr, 16);
    chk("load_bits", cap, cfg);
    chk("load_first_rise", first, CLK_DIV);
    chk("load_rise_spacing", gap_bad, 0);
    chk("load_dat_stable", stab_bad, 0);
    chk("load_clk_low_exit", lfsr_clk_o, 0);
    chk("arst_low_cycles", nlow, LOAD_CYC + SETTLE);
    chk("run_rst_n_high", alfsr_rst_n_o, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [15:0] c;
    int nv, len, t;

    repeat (3) step();
    check_rst_vals("reset");
    rst = 1'b0;
    step();

    // all-ones stream, consumer always ready
    rng_in = 1'b1;
    byte_ready = 1'b1;
    do_start(16'hA5C3);
    chk("busy_after_start", busy, 1);
    check_load(16'hA5C3);
    nv = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (byte_valid) begin
        nv++;
        chk("ff_byte", byte_o, 8'hFF);
      end
    end
    chk("ff_valid_cycles", nv, 4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_rst_n", alfsr_rst_n_o, 0);
    repeat (4) step();

    // alternating stream, consumer stalled: first byte held, next one dropped
    byte_ready = 1'b0;
    rng_in = 1'b1;
    c = 16'($urandom);
    do_start(c);
    check_load(c);
    for (int i = 0; i < 40; i++) begin
      t = cyc - m_r0 + 1;
      rng_in = ((t >> 1) & 1) == 0;
      step();
    end
    chk("alt_byte_held", byte_o, 8'hAA);
    chk("alt_overrun", overrun, 1);
    chk("alt_valid", byte_valid, 1);
    stop = 1'b1;
    byte_ready = 1'b1;
    step();
    stop = 1'b0;
    byte_ready = 1'b0;
    repeat (3) step();

    // reset in the middle of LOAD, then a fresh load
    do_start(16'h5A3C);
    repeat (5 * 2 * CLK_DIV + 2) step();
    rst = 1'b1;
    #1;
    check_rst_vals("midload_async");
    step();
    check_rst_vals("midload_edge");
    rst = 1'b0;
    step();
    c = 16'($urandom);
    do_start(c);
    check_load(c);
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (2) step();

    // stop after three samples
    rng_in = 1'b1;
    do_start(16'($urandom));
    check_load(cfg_word);
    for (int i = 0; i < 2 * SAMPLE_DIV + 2; i++) begin
      rng_in = 1'($urandom);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop3_busy", busy, 0);
    chk("stop3_rst_n", alfsr_rst_n_o, 0);
    chk("stop3_valid", byte_valid, 0);
    repeat (20) step();
    chk("stop3_no_byte", byte_valid, 0);

    // randomized runs with random back-pressure and ignored start pulses
    for (int it = 0; it < 6; it++) begin
      c = 16'($urandom);
      do_start(c);
      check_load(c);
      len = $urandom_range(40, 200);
      for (int i = 0; i < len; i++) begin
        rng_in = 1'($urandom);
        byte_ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 15) == 0);
        step();
        start = 1'b0;
      end
      stop = 1'b1;
      byte_ready = 1'b1;
      step();
      stop = 1'b0;
      repeat (3) step();
      byte_ready = 1'b0;
      step();
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alfsr_seq.md
ALFSR_SEQ -- requirements
Module: alfsr_seq

Interface
REQ-001 Parameter CFG_BITS, default 16: width of the configuration word shifted into the LFSR configurator.
REQ-002 Parameter CLK_DIV, default 4: clk cycles per phase (low, then high) of one lfsr_clk_o bit period.
REQ-003 Parameter SETTLE, default 8: clk cycles alfsr_rst_n_o is held low after configuration.
REQ-004 Parameter SAMPLE_DIV, default 2: clk cycles between successive rng samples.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to configure and run; honoured only in IDLE.
REQ-008 stop  input  1  level; while high in RUN, the block returns to IDLE.
REQ-009 cfg_word  input  CFG_BITS  configuration word, captured on the accepted start.
REQ-010 lfsr_clk_o  output  1  serial clock to the LFSR configurator.
REQ-011 lfsr_dat_o  output  1  serial configuration data, MSB first.
REQ-012 alfsr_rst_n_o  output  1  active-low reset to the ALFSR core.
REQ-013 rng_in  input  1  digitised ALFSR output; asynchronous to clk.
REQ-014 byte_o  output  8  packed random byte.
REQ-015 byte_valid  output  1  byte_o holds an unconsumed byte.
REQ-016 byte_ready  input  1  consumer accepts byte_o when byte_valid and byte_ready are both high.
REQ-017 busy  output  1  high in every state other than IDLE.
REQ-018 overrun  output  1  sticky; set when a completed byte is dropped.

Function
REQ-019 FSM states: IDLE, LOAD, ARST, RUN; no other reachable states.
REQ-020 IDLE->LOAD on start; cfg_word is latched into a shift register and overrun is cleared in the same cycle.
REQ-021 LOAD, per bit: lfsr_dat_o = current MSB; lfsr_clk_o low CLK_DIV cycles, then high CLK_DIV cycles; shift left on the falling edge of lfsr_clk_o (cycle after the high phase).
REQ-022 lfsr_dat_o is stable throughout each high phase of lfsr_clk_o.
REQ-023 LOAD lasts exactly CFG_BITS*2*CLK_DIV cycles, then ARST; lfsr_clk_o is low on exit.
REQ-024 ARST: alfsr_rst_n_o = 0 for exactly SETTLE cycles, then RUN.
REQ-025 alfsr_rst_n_o = 1 in RUN; it is 0 in IDLE, LOAD and ARST.
REQ-026 rng_in passes through a 2-flop synchroniser; only the synchronised value is sampled.
REQ-027 RUN: one sample every SAMPLE_DIV cycles, first sample SAMPLE_DIV cycles after entering RUN; samples shift into the LSB of an 8-bit packer.
REQ-028 On the 8th sample, if byte_valid=0 or a handshake occurs that same cycle: byte_o <= packer and byte_valid <= 1.
REQ-029 On the 8th sample with byte_valid=1 and no handshake: new byte dropped, byte_o unchanged, overrun <= 1.
REQ-030 A handshake with no new byte in the same cycle clears byte_valid the next cycle.
REQ-031 After every 8th sample the packer bit count restarts at 0.
REQ-032 stop high in RUN -> IDLE next cycle; the partial packer is discarded; a pending byte stays valid until handshaked.
REQ-033 start and stop outside their states are ignored; start in RUN does not restart.
REQ-034 byte_valid/byte_o are updated by the handshake in any state.

Reset
REQ-035 rst asserted at any time, including mid-LOAD or mid-RUN, forces IDLE immediately.
REQ-036 Reset values: lfsr_clk_o=0, lfsr_dat_o=0, alfsr_rst_n_o=0, byte_o=0, byte_valid=0, busy=0, overrun=0; shift register, packer, counters and synchroniser all 0.

Verification
REQ-037 Defaults, cfg_word=16'hA5C3, start pulse -> 16 lfsr_clk_o rising edges 8 cycles apart; bits captured at rising edges = A5C3; ARST begins 128 cycles after start.
REQ-038 After LOAD -> alfsr_rst_n_o low exactly 8 cycles, then high; busy high from the cycle after start onward.
REQ-039 RUN with rng_in held 1 and byte_ready=1 -> byte_o=8'hFF, byte_valid high for one cycle every 16 cycles.
REQ-040 rng_in toggled each sample (1 first), byte_ready=0 -> first byte 8'hAA held; the next completed byte sets overrun and byte_o stays 8'hAA.
REQ-041 rst pulse mid-LOAD at bit 5 -> all outputs at REQ-036 values next edge; a fresh start reloads all 16 bits.
REQ-042 stop after 3 samples -> IDLE next cycle, no byte emitted, alfsr_rst_n_o=0, busy=0.
